// File: rtl/tri_pkg.sv
// Shared types and constants for the triangle pattern writer: vertex/triangle
// layouts, pattern modes, FSM states and the fixed triangle table.
package tri_pkg;

  localparam int TRI_COORD_W = 10;

  typedef logic [TRI_COORD_W-1:0] coord_t;
  typedef coord_t [1:0]           vertex_t;    // [0]=x, [1]=y
  typedef vertex_t [2:0]          triangle_t;

  typedef enum logic [1:0] {
    MODE_TABLE = 2'd0,
    MODE_GRID  = 2'd1,
    MODE_LFSR  = 2'd2
  } pat_mode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GEN   = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } wr_state_e;

  // Indexed [entry][vertex][0=x,1=y].
  localparam int TRI_TABLE [4][3][2] = '{
    '{'{100,  40}, '{ 40, 120}, '{ 20,  60}},
    '{'{100, 140}, '{140, 120}, '{120, 160}},
    '{'{200, 240}, '{240, 220}, '{220, 260}},
    '{'{300, 100}, '{360, 100}, '{330, 160}}
  };

endpackage

// File: rtl/tri_lfsr16.sv
// 16-bit Fibonacci LFSR, shifting left with taps 15,13,12,10 fed into bit 0.
module tri_lfsr16 #(
  parameter logic [15:0] RESET_SEED = 16'hACE1
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  logic feedback;

  assign feedback = state[15] ^ state[13] ^ state[12] ^ state[10];

  // Load wins over enable so a restart always begins from the seed.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)    state <= RESET_SEED;
    else if (load)   state <= seed;
    else if (enable) state <= {state[14:0], feedback};
  end

endmodule

// File: rtl/tri_pattern_writer.sv
// Generates NUM_TRI screen-space triangles (table, grid or LFSR pattern) and
// pushes them one per write into a triangle FIFO.
module tri_pattern_writer
  import tri_pkg::*;
#(
  parameter int          COORD_W   = 10,
  parameter int          NUM_TRI   = 8,
  parameter int          SCREEN_W  = 640,
  parameter int          SCREEN_H  = 480,
  parameter int          GRID_STEP = 40,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic                          clear_start,
  input  logic [1:0]                    mode,
  input  logic                          fifo_full,
  output logic                          fifo_w,
  output logic [2:0][1:0][COORD_W-1:0]  proj_triangle_in,
  output logic                          busy,
  output logic                          done,
  output logic [7:0]                    tri_count,
  output wr_state_e                     dbg_state
);

  localparam int AW = COORD_W + 4;
  typedef logic [AW-1:0] wide_t;
  typedef logic [2:0][1:0][COORD_W-1:0] tri_vec_t;

  localparam wide_t X_MAX = wide_t'(SCREEN_W - 1);
  localparam wide_t Y_MAX = wide_t'(SCREEN_H - 1);
  localparam wide_t GSTEP = wide_t'(GRID_STEP);
  localparam logic [15:0] COORD_MASK = 16'((1 << COORD_W) - 1);

  function automatic logic [COORD_W-1:0] clamp(input wide_t v, input wide_t lim);
    return (v > lim) ? lim[COORD_W-1:0] : v[COORD_W-1:0];
  endfunction

  wr_state_e   state;
  pat_mode_e   mode_q;
  logic [2:0]  sub;
  logic [15:0] lfsr_state;
  logic [15:0] lfsr_low;
  logic        lfsr_en;
  logic        lfsr_load;
  wide_t       gx0, gy0;
  tri_vec_t    grid_tri, tbl_tri;
  logic [COORD_W-1:0] lfsr_coord;

  assign dbg_state = state;
  assign busy      = (state == S_GEN) || (state == S_WRITE);
  assign done      = (state == S_DONE);

  // FIFO handshake: fifo_full acts as !ready. A triangle transfers on every
  // cycle fifo_w is high; fifo_w is only raised in Write and only while the
  // FIFO is not full, and the triangle register is frozen until it transfers.
  assign fifo_w    = (state == S_WRITE) && !fifo_full;

  assign lfsr_en   = (state == S_GEN) && (mode_q == MODE_LFSR);
  assign lfsr_load = (state == S_IDLE) && clear_start;
  assign lfsr_low  = lfsr_state & COORD_MASK;

  tri_lfsr16 #(.RESET_SEED(LFSR_SEED)) u_lfsr (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .enable  (lfsr_en),
    .load    (lfsr_load),
    .seed    (LFSR_SEED),
    .state   (lfsr_state)
  );

  always_comb begin
    gx0 = wide_t'(tri_count[2:0]) * GSTEP;
    gy0 = wide_t'(tri_count[7:3]) * GSTEP;
    grid_tri       = '0;
    grid_tri[0][0] = clamp(gx0,         X_MAX);
    grid_tri[0][1] = clamp(gy0,         Y_MAX);
    grid_tri[1][0] = clamp(gx0 + GSTEP, X_MAX);
    grid_tri[1][1] = clamp(gy0,         Y_MAX);
    grid_tri[2][0] = clamp(gx0,         X_MAX);
    grid_tri[2][1] = clamp(gy0 + GSTEP, Y_MAX);
  end

  always_comb begin
    tbl_tri = '0;
    for (int v = 0; v < 3; v++) begin
      for (int c = 0; c < 2; c++) begin
        tbl_tri[v][c] = COORD_W'(TRI_TABLE[tri_count[1:0]][v][c]);
      end
    end
  end

  // Even sub-steps capture an x coordinate, odd ones a y coordinate.
  assign lfsr_coord = clamp(wide_t'(lfsr_low), sub[0] ? Y_MAX : X_MAX);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state            <= S_IDLE;
      mode_q           <= MODE_TABLE;
      sub              <= 3'd0;
      tri_count        <= 8'd0;
      proj_triangle_in <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (clear_start) begin
            case (mode)
              2'd1:    mode_q <= MODE_GRID;
              2'd2:    mode_q <= MODE_LFSR;
              default: mode_q <= MODE_TABLE;
            endcase
            tri_count <= 8'd0;
            sub       <= 3'd0;
            state     <= S_GEN;
          end
        end
        S_GEN: begin
          if (mode_q == MODE_LFSR) begin
            proj_triangle_in[sub[2:1]][sub[0]] <= lfsr_coord;
            if (sub == 3'd5) begin
              sub   <= 3'd0;
              state <= S_WRITE;
            end else begin
              sub <= sub + 3'd1;
            end
          end else begin
            proj_triangle_in <= (mode_q == MODE_GRID) ? grid_tri : tbl_tri;
            state            <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (!fifo_full) begin
            tri_count <= tri_count + 8'd1;
            state     <= (tri_count + 8'd1 == 8'(NUM_TRI)) ? S_DONE : S_GEN;
          end
        end
        S_DONE: begin
          if (!clear_start) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tri_pattern_writer.sv
// Randomized bench: two writers (grid pitch 40 and 400) share stimulus and are
// scored against an arithmetic model of the triangle sequence and write timing.
module tb_tri_pattern_writer;

  localparam int NT = 17;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       clear_start = 1'b0;
  logic       fifo_full = 1'b0;
  logic [1:0] mode = 2'd0;

  logic             fifo_w_a, fifo_w_b, busy_a, busy_b, done_a, done_b;
  logic [2:0][1:0][9:0] tri_a, tri_b;
  logic [7:0]       cnt_a, cnt_b;
  logic [1:0]       dbg_a, dbg_b;

  int n_vec = 0;
  int n_bad = 0;
  logic [59:0] exp_q_a[$];
  logic [59:0] exp_q_b[$];

  int tbl [4][6] = '{
    '{100,  40,  40, 120,  20,  60},
    '{100, 140, 140, 120, 120, 160},
    '{200, 240, 240, 220, 220, 260},
    '{300, 100, 360, 100, 330, 160}
  };

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;

  tri_pattern_writer #(.NUM_TRI(NT), .GRID_STEP(40)) dut_a (
    .Clk(Clk), .Reset_n(Reset_n), .clear_start(clear_start), .mode(mode),
    .fifo_full(fifo_full), .fifo_w(fifo_w_a), .proj_triangle_in(tri_a),
    .busy(busy_a), .done(done_a), .tri_count(cnt_a), .dbg_state(dbg_a)
  );

  tri_pattern_writer #(.NUM_TRI(NT), .GRID_STEP(400)) dut_b (
    .Clk(Clk), .Reset_n(Reset_n), .clear_start(clear_start), .mode(mode),
    .fifo_full(fifo_full), .fifo_w(fifo_w_b), .proj_triangle_in(tri_b),
    .busy(busy_b), .done(done_b), .tri_count(cnt_b), .dbg_state(dbg_b)
  );

  // ---------------- checker ----------------
  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [9:0] cl(input int v, input int lim);
    return (v > lim) ? 10'(lim) : 10'(v);
  endfunction

  function automatic logic [59:0] pack(input int x0, input int y0, input int x1,
                                       input int y1, input int x2, input int y2);
    return {cl(y2, 479), cl(x2, 639), cl(y1, 479), cl(x1, 639), cl(y0, 479), cl(x0, 639)};
  endfunction

  function automatic logic [59:0] grid_model(input int k, input int step);
    int x0, y0;
    x0 = (k % 8) * step;
    y0 = (k / 8) * step;
    return pack(x0, y0, x0 + step, y0, x0, y0 + step);
  endfunction

  task automatic build_expected(input int md);
    int lfsr, fb;
    int c [6];
    logic [59:0] t;
    exp_q_a.delete();
    exp_q_b.delete();
    lfsr = 16'hACE1;
    for (int k = 0; k < NT; k++) begin
      if (md == 2) begin
        for (int i = 0; i < 6; i++) begin
          c[i] = lfsr % 1024;
          fb   = ((lfsr >> 15) ^ (lfsr >> 13) ^ (lfsr >> 12) ^ (lfsr >> 10)) & 1;
          lfsr = ((lfsr * 2) % 65536) + fb;
        end
        t = pack(c[0], c[1], c[2], c[3], c[4], c[5]);
        exp_q_a.push_back(t);
        exp_q_b.push_back(t);
      end else if (md == 1) begin
        exp_q_a.push_back(grid_model(k, 40));
        exp_q_b.push_back(grid_model(k, 400));
      end else begin
        t = pack(tbl[k%4][0], tbl[k%4][1], tbl[k%4][2], tbl[k%4][3], tbl[k%4][4], tbl[k%4][5]);
        exp_q_a.push_back(t);
        exp_q_b.push_back(t);
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_pattern(input int md);
    int g, c, wr, elig;
    logic ew;
    build_expected(md);
    g = (md == 2) ? 6 : 1;
    @(negedge Clk);
    mode = 2'(md);
    clear_start = 1'b1;
    fifo_full = 1'b0;
    c = 0;
    wr = 0;
    elig = g + 1;
    while (wr < NT && c < 3000) begin
      @(negedge Clk);
      c++;
      fifo_full = ($urandom_range(0, 9) < 3);
      mode = 2'($urandom_range(0, 3));
      #1;
      ew = (c >= elig) && !fifo_full;
      expect_eq("fifo_w_a", fifo_w_a, ew);
      expect_eq("fifo_w_b", fifo_w_b, ew);
      expect_eq("busy", busy_a, 1'b1);
      expect_eq("done_in_run", done_a, 1'b0);
      expect_eq("tri_count", cnt_a, wr);
      if (c >= elig) begin
        expect_eq($sformatf("tri_a m%0d k%0d", md, wr), tri_a, exp_q_a[0]);
        expect_eq($sformatf("tri_b m%0d k%0d", md, wr), tri_b, exp_q_b[0]);
        if (!fifo_full) begin
          void'(exp_q_a.pop_front());
          void'(exp_q_b.pop_front());
          wr++;
          elig = c + g + 1;
        end
      end
    end
    expect_eq("run_complete", wr, NT);
    // Start request still held high: must sit in Done without restarting.
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      fifo_full = ($urandom_range(0, 1) == 1);
      #1;
      expect_eq("done_hold", done_a, 1'b1);
      expect_eq("busy_done", busy_a, 1'b0);
      expect_eq("fifo_w_done", fifo_w_a, 1'b0);
      expect_eq("count_done", cnt_a, NT);
    end
    clear_start = 1'b0;
    @(negedge Clk);
    #1;
    expect_eq("idle_done", done_a, 1'b0);
    expect_eq("idle_busy", busy_a, 1'b0);
    expect_eq("idle_count", cnt_a, NT);
    expect_eq("idle_fifo_w", fifo_w_b, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int c;
    #1;
    expect_eq("rst_fifo_w", fifo_w_a, 1'b0);
    expect_eq("rst_busy", busy_a, 1'b0);
    expect_eq("rst_done", done_a, 1'b0);
    expect_eq("rst_count", cnt_a, 8'd0);
    expect_eq("rst_tri", tri_a, 60'd0);
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;

    run_pattern(0);
    run_pattern(1);
    run_pattern(2);
    run_pattern(2);
    run_pattern(3);

    // Abort a run asynchronously while generating triangle 3.
    @(negedge Clk);
    mode = 2'd0;
    fifo_full = 1'b0;
    clear_start = 1'b1;
    c = 0;
    while (cnt_a != 8'd3 && c < 100) begin
      @(negedge Clk);
      c++;
    end
    expect_eq("abort_wait", cnt_a, 8'd3);
    #2;
    Reset_n = 1'b0;
    #1;
    expect_eq("abort_fifo_w", fifo_w_a, 1'b0);
    expect_eq("abort_busy", busy_a, 1'b0);
    expect_eq("abort_done", done_a, 1'b0);
    expect_eq("abort_count", cnt_a, 8'd0);
    expect_eq("abort_tri_a", tri_a, 60'd0);
    expect_eq("abort_tri_b", tri_b, 60'd0);
    clear_start = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      #1;
      expect_eq("post_abort_fifo_w", fifo_w_a, 1'b0);
      expect_eq("post_abort_busy", busy_a, 1'b0);
    end

    run_pattern(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
